// File: rtl/tx_pulse_shaper.sv
// -----------------------------------------------------------------------------
// tx_pulse_shaper
//
// Polyphase FIR pulse shaper for a binary (BPSK-style) transmit path. A PRBS9
// generator supplies symbols. Each symbol is held for OS output samples. Every
// output sample is the sum of NTAPS symbol taps weighted by the polyphase
// coefficient branch selected by the current phase. The coefficients can be
// rewritten at run time through a simple write port.
//
// Ports
//   i_clock       system clock, rising edge
//   i_reset       asynchronous, active-low reset
//   i_en          clock enable for filter, phase, PRBS and tap state
//   i_coeff_we    coefficient write strobe (works regardless of i_en)
//   i_coeff_addr  coefficient index = tap*OS + phase
//   i_coeff_data  signed coefficient value, S(NB_COEFF, NB_COEFF-1)
//   o_sample      registered shaped sample, S(NB_OUT, NB_OUT-1), saturated
//   o_valid       i_en delayed by one edge
//   o_bit         most recent PRBS bit shifted into the tap line
// -----------------------------------------------------------------------------
module tx_pulse_shaper #(
  parameter int OS       = 4,
  parameter int NTAPS    = 6,
  parameter int NB_COEFF = 8,
  parameter int NB_OUT   = 8
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_en,
  input  logic                       i_coeff_we,
  input  logic [4:0]                 i_coeff_addr,
  input  logic signed [NB_COEFF-1:0] i_coeff_data,
  output logic signed [NB_OUT-1:0]   o_sample,
  output logic                       o_valid,
  output logic                       o_bit
);

  localparam int NCOEF  = OS * NTAPS;
  localparam int CI_W   = (NCOEF > 1) ? $clog2(NCOEF) : 1;
  localparam int PH_W   = (OS > 1) ? $clog2(OS) : 1;
  // One product is at most 2^(NB_COEFF-1) in magnitude (the -1 * -max case),
  // so NTAPS of them need clog2(NTAPS) growth bits plus one for that corner.
  localparam int NB_SUM = NB_COEFF + $clog2(NTAPS) + 1;

  localparam logic [PH_W-1:0]              PH_LAST    = PH_W'(OS - 1);
  localparam logic signed [NB_SUM-1:0]     SAT_MAX    = NB_SUM'((2 ** (NB_OUT - 1)) - 1);
  localparam logic signed [NB_SUM-1:0]     SAT_MIN    = NB_SUM'(-(2 ** (NB_OUT - 1)));
  localparam logic signed [NB_COEFF-1:0]   COEF_UNITY = NB_COEFF'((2 ** (NB_COEFF - 1)) - 1);
  localparam logic [8:0]                   LFSR_SEED  = 9'h1FF;

  // Coefficient table (kept in registers because it has a non-zero reset image)
  logic signed [NB_COEFF-1:0] coeff_q [NCOEF];

  // Symbol generation / tap line state
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [8:0]       lfsr_q, lfsr_d;
  logic [NTAPS-1:0] tap_valid_q, tap_valid_d;
  logic [NTAPS-1:0] tap_bit_q, tap_bit_d;
  logic             bit_q, bit_d;

  // Output registers
  logic signed [NB_OUT-1:0] sample_q, sample_d;
  logic                     valid_q;

  // Datapath
  logic [CI_W-1:0]          cidx      [NTAPS];
  logic signed [NB_SUM-1:0] coeff_ext [NTAPS];
  logic signed [NB_SUM-1:0] term      [NTAPS];
  logic signed [NB_SUM-1:0] sum;

  // ---------------------------------------------------------------------------
  // Coefficient table: one register per entry. Addresses at or beyond NCOEF
  // match no entry, so such writes are dropped.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NCOEF; gi++) begin : g_coeff
      always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
          coeff_q[gi] <= (gi == 0) ? COEF_UNITY : '0;
        end else if (i_coeff_we && (i_coeff_addr == 5'(gi))) begin
          coeff_q[gi] <= i_coeff_data;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Per-tap product. The symbol is +1, -1 or 0, so the multiply is a select
  // between the coefficient, its negation and zero.
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NTAPS; gi++) begin : g_tap
      assign cidx[gi]      = CI_W'(gi * OS) + CI_W'(phase_q);
      assign coeff_ext[gi] = NB_SUM'(coeff_q[cidx[gi]]);
      // A set bit maps to symbol -1, a clear bit to +1.
      assign term[gi]      = !tap_valid_q[gi] ? '0 :
                             (tap_bit_q[gi] ? -coeff_ext[gi] : coeff_ext[gi]);
    end
  endgenerate

  always_comb begin
    sum = '0;
    for (int i = 0; i < NTAPS; i++) begin
      sum = sum + term[i];
    end
  end

  // The output keeps the coefficient's binary point, so saturation is a plain
  // clamp followed by truncation to NB_OUT bits.
  always_comb begin
    sample_d = NB_OUT'(sum);
    if (sum > SAT_MAX) begin
      sample_d = NB_OUT'(SAT_MAX);
    end else if (sum < SAT_MIN) begin
      sample_d = NB_OUT'(SAT_MIN);
    end
  end

  // ---------------------------------------------------------------------------
  // Phase counter, PRBS9 and tap line next state
  // ---------------------------------------------------------------------------
  always_comb begin
    phase_d     = phase_q;
    lfsr_d      = lfsr_q;
    tap_valid_d = tap_valid_q;
    tap_bit_d   = tap_bit_q;
    bit_d       = bit_q;
    if (i_en) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
      // A new symbol enters at the last phase, so the next edge (phase 0)
      // is the first sample computed with it.
      if (phase_q == PH_LAST) begin
        tap_valid_d = {tap_valid_q[NTAPS-2:0], 1'b1};
        tap_bit_d   = {tap_bit_q[NTAPS-2:0], lfsr_q[8]};
        bit_d       = lfsr_q[8];
        lfsr_d      = {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      phase_q     <= '0;
      lfsr_q      <= LFSR_SEED;
      tap_valid_q <= '0;
      tap_bit_q   <= '0;
      bit_q       <= 1'b0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      lfsr_q      <= lfsr_d;
      tap_valid_q <= tap_valid_d;
      tap_bit_q   <= tap_bit_d;
      bit_q       <= bit_d;
      valid_q     <= i_en;
      if (i_en) begin
        sample_q <= sample_d;
      end
    end
  end

  assign o_sample = sample_q;
  assign o_valid  = valid_q;
  assign o_bit    = bit_q;

endmodule

// File: tb/tb_tx_pulse_shaper.sv
// -----------------------------------------------------------------------------
// tb_tx_pulse_shaper
//
// Directed self-checking bench for tx_pulse_shaper: reset image, impulse
// response of the default table, PRBS9 sequence, saturation, coefficient write
// timing and address range, a hot RRC-like table against a behavioural model,
// clock-enable gaps and asynchronous reset mid-stream.
// -----------------------------------------------------------------------------
module tb_tx_pulse_shaper;

  localparam int OS    = 4;
  localparam int NTAPS = 6;
  localparam int NCOEF = OS * NTAPS;

  // RRC-like table, deliberately hot so that many sums clip.
  localparam int RRC [NCOEF] = '{
     -3,  -6,  -5,   0,
      8,  14,  12,   0,
    -22, -45, -40,   0,
    127, 120,  90,  45,
    -40, -45, -22,   0,
     12,  14,   8,  -6
  };

  logic              i_clock;
  logic              i_reset;
  logic              i_en;
  logic              i_coeff_we;
  logic [4:0]        i_coeff_addr;
  logic signed [7:0] i_coeff_data;
  logic signed [7:0] o_sample;
  logic              o_valid;
  logic              o_bit;

  int tests_run;
  int tests_failed;

  tx_pulse_shaper #(
    .OS       (OS),
    .NTAPS    (NTAPS),
    .NB_COEFF (8),
    .NB_OUT   (8)
  ) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_en         (i_en),
    .i_coeff_we   (i_coeff_we),
    .i_coeff_addr (i_coeff_addr),
    .i_coeff_data (i_coeff_data),
    .o_sample     (o_sample),
    .o_valid      (o_valid),
    .o_bit        (o_bit)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  // ---------------------------------------------------------------------------
  // Behavioural reference, written directly from the signal definitions
  // ---------------------------------------------------------------------------
  int         m_coeff [NCOEF];
  int         m_sym   [NTAPS];
  int         m_phase;
  logic [8:0] m_lfsr;
  logic [7:0] m_sample;
  logic       m_valid;
  logic       m_bit;

  task automatic model_reset();
    for (int i = 0; i < NCOEF; i++) m_coeff[i] = 0;
    m_coeff[0] = 127;
    for (int t = 0; t < NTAPS; t++) m_sym[t] = 0;
    m_phase  = 0;
    m_lfsr   = 9'h1FF;
    m_sample = 8'h00;
    m_valid  = 1'b0;
    m_bit    = 1'b0;
  endtask

  task automatic model_edge(input logic en, input logic we, input int addr, input int data);
    int acc;
    if (en) begin
      acc = 0;
      for (int t = 0; t < NTAPS; t++) acc += m_sym[t] * m_coeff[t * OS + m_phase];
      if (acc > 127) acc = 127;
      else if (acc < -128) acc = -128;
      m_sample = 8'(acc);
      if (m_phase == OS - 1) begin
        for (int t = NTAPS - 1; t > 0; t--) m_sym[t] = m_sym[t - 1];
        m_sym[0] = m_lfsr[8] ? -1 : 1;
        m_bit    = m_lfsr[8];
        m_lfsr   = {m_lfsr[7:0], m_lfsr[8] ^ m_lfsr[4]};
      end
      m_phase = (m_phase + 1) % OS;
    end
    m_valid = en;
    // The write lands after this edge's computation.
    if (we && addr < NCOEF) m_coeff[addr] = data;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no checking inside)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic drive_edge(input logic en, input logic we, input int addr, input int data);
    i_en         = en;
    i_coeff_we   = we;
    i_coeff_addr = 5'(addr);
    i_coeff_data = 8'(data);
    tick();
    model_edge(en, we, addr, data);
    i_coeff_we   = 1'b0;
  endtask

  task automatic do_reset();
    i_en       = 1'b0;
    i_coeff_we = 1'b0;
    i_reset    = 1'b0;
    tick();
    tick();
    i_reset    = 1'b1;
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    i_en       = 1'b1;
    i_coeff_we = 1'b0;
    i_reset    = 1'b0;
    tick();
    tick();
    tick();
    tests_run++;
    if (o_sample !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_sample: got %h expected 00", o_sample);
    end else $display("[TB] reset_sample ok: %h", o_sample);
    tests_run++;
    if (o_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_valid: got %b expected 0", o_valid);
    end else $display("[TB] reset_valid ok: %b", o_valid);
    tests_run++;
    if (o_bit !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_bit: got %b expected 0", o_bit);
    end else $display("[TB] reset_bit ok: %b", o_bit);
    i_en = 1'b0;
    i_reset = 1'b1;
    model_reset();
  endtask

  task automatic test_impulse(input string tag);
    logic [7:0] exp_s [8];
    exp_s = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00};
    for (int e = 0; e < 8; e++) begin
      i_en = 1'b1;
      tick();
      tests_run++;
      if (o_sample !== exp_s[e] || o_valid !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL %s edge %0d: got sample=%h valid=%b expected sample=%h valid=1",
                 tag, e + 1, o_sample, o_valid, exp_s[e]);
      end else $display("[TB] %s edge %0d ok: sample=%h valid=%b", tag, e + 1, o_sample, o_valid);
      if (e == 3) begin
        tests_run++;
        if (o_bit !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL %s first_bit: got %b expected 1", tag, o_bit);
        end
      end
    end
    i_en = 1'b0;
  endtask

  task automatic test_prbs();
    logic [8:0] r;
    logic       rb;
    logic       bits [1022];
    do_reset();
    r = 9'h1FF;
    i_en = 1'b1;
    for (int s = 0; s < 1022; s++) begin
      for (int p = 0; p < OS; p++) tick();
      bits[s] = o_bit;
      rb = r[8];
      r  = {r[7:0], r[8] ^ r[4]};
      tests_run++;
      if (o_bit !== rb) begin
        tests_failed++;
        $display("[TB] FAIL prbs_ref symbol %0d: got %b expected %b", s, o_bit, rb);
      end
    end
    i_en = 1'b0;
    for (int s = 0; s < 10; s++) begin
      tests_run++;
      if (bits[s] !== ((s < 9) ? 1'b1 : 1'b0)) begin
        tests_failed++;
        $display("[TB] FAIL prbs_start symbol %0d: got %b expected %b", s, bits[s], (s < 9) ? 1'b1 : 1'b0);
      end else $display("[TB] prbs_start symbol %0d ok: %b", s, bits[s]);
    end
    for (int s = 0; s < 511; s++) begin
      tests_run++;
      if (bits[s + 511] !== bits[s]) begin
        tests_failed++;
        $display("[TB] FAIL prbs_period symbol %0d: got %b expected %b", s + 511, bits[s + 511], bits[s]);
      end
    end
    $display("[TB] prbs 1022 symbols checked against reference and period 511");
  endtask

  task automatic test_saturation();
    do_reset();
    i_coeff_we = 1'b1; i_coeff_addr = 5'd0; i_coeff_data = 8'h80;
    tick();
    i_coeff_we = 1'b0;
    i_en = 1'b1;
    for (int e = 1; e <= 41; e++) begin
      tick();
      // Symbols 1..9 are -1 (-1*-128 clips to 127); symbol 10 is +1 (-128).
      if (e == 4 || e == 5 || e == 6 || e == 9 || e == 37 || e == 41) begin
        logic [7:0] ex;
        ex = (e == 4 || e == 6) ? 8'h00 : ((e == 41) ? 8'h80 : 8'h7F);
        tests_run++;
        if (o_sample !== ex) begin
          tests_failed++;
          $display("[TB] FAIL sat edge %0d: got %h expected %h", e, o_sample, ex);
        end else $display("[TB] sat edge %0d ok: %h", e, o_sample);
      end
    end
    i_en = 1'b0;
  endtask

  task automatic test_write_timing();
    do_reset();
    // Out-of-range writes must not land anywhere in the table.
    i_coeff_we = 1'b1; i_coeff_addr = 5'd24; i_coeff_data = 8'h10;
    tick();
    i_coeff_addr = 5'd31; i_coeff_data = 8'h40;
    tick();
    i_coeff_we = 1'b0;
    i_en = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      // Write coeff[0] on the same edge that first uses symbol 1.
      if (e == 5) begin
        i_coeff_we = 1'b1; i_coeff_addr = 5'd0; i_coeff_data = 8'h80;
      end else i_coeff_we = 1'b0;
      tick();
      if (e == 5 || e == 6 || e == 9 || e == 13 || e == 16) begin
        logic [7:0] ex;
        ex = (e == 5) ? 8'h81 : ((e == 6 || e == 16) ? 8'h00 : 8'h7F);
        tests_run++;
        if (o_sample !== ex) begin
          tests_failed++;
          $display("[TB] FAIL wr_timing edge %0d: got %h expected %h", e, o_sample, ex);
        end else $display("[TB] wr_timing edge %0d ok: %h", e, o_sample);
      end
    end
    i_coeff_we = 1'b0;
    i_en = 1'b0;
  endtask

  task automatic test_rrc();
    int errs;
    do_reset();
    for (int i = 0; i < NCOEF; i++) drive_edge(1'b0, 1'b1, i, RRC[i]);
    errs = 0;
    for (int n = 0; n < 2000; n++) begin
      drive_edge(1'b1, 1'b0, 0, 0);
      tests_run++;
      if (o_sample !== m_sample || o_bit !== m_bit) begin
        tests_failed++;
        errs++;
        $display("[TB] FAIL rrc sample %0d: got sample=%h bit=%b expected sample=%h bit=%b",
                 n, o_sample, o_bit, m_sample, m_bit);
      end
    end
    $display("[TB] rrc 2000 samples compared, %0d differences", errs);
  endtask

  task automatic test_en_gap();
    // Continues from the RRC stream; two 3-cycle gaps at different phases.
    for (int n = 0; n < 40; n++) begin
      logic en;
      en = !((n >= 10 && n <= 12) || (n >= 25 && n <= 27));
      drive_edge(en, 1'b0, 0, 0);
      tests_run++;
      if (o_sample !== m_sample || o_bit !== m_bit || o_valid !== m_valid) begin
        tests_failed++;
        $display("[TB] FAIL en_gap edge %0d: got sample=%h bit=%b valid=%b expected sample=%h bit=%b valid=%b",
                 n, o_sample, o_bit, o_valid, m_sample, m_bit, m_valid);
      end else $display("[TB] en_gap edge %0d ok: en=%b sample=%h bit=%b valid=%b",
                        n, en, o_sample, o_bit, o_valid);
    end
  endtask

  task automatic test_async_reset();
    drive_edge(1'b1, 1'b1, 5, 8'h33);
    for (int n = 0; n < 7; n++) drive_edge(1'b1, 1'b0, 0, 0);
    // Assert reset between edges and look before any further clock edge.
    #2;
    i_reset = 1'b0;
    #1;
    tests_run++;
    if (o_sample !== 8'h00 || o_valid !== 1'b0 || o_bit !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got sample=%h valid=%b bit=%b expected 00/0/0",
               o_sample, o_valid, o_bit);
    end else $display("[TB] async_reset ok: sample=%h valid=%b bit=%b", o_sample, o_valid, o_bit);
    i_en = 1'b0;
    tick();
    tick();
    i_reset = 1'b1;
    model_reset();
    test_impulse("post_reset");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    i_reset      = 1'b0;
    i_en         = 1'b0;
    i_coeff_we   = 1'b0;
    i_coeff_addr = 5'd0;
    i_coeff_data = 8'h00;
    test_reset();
    test_impulse("impulse");
    test_prbs();
    test_saturation();
    test_write_timing();
    test_rrc();
    test_en_gap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
